keypad_scan_ctrl: RTL and testbench

Controller for the 4x4 matrix keypad. It sequences the one-hot column drive and samples the row lines. It debounces the result with a press/release state machine and delivers each accepted key as a 4-bit code through a small FIFO with a valid/ready handshake. It sits between the keypad pins and the operation/ALU logic, replacing free-running, unqualified key flags with clean single-shot key events.

---
 rtl/keypad_scan_ctrl_pkg.sv | 42 ++++
 rtl/keypad_scan_ctrl_if.sv | 36 +++
 rtl/keypad_scan_ctrl_fifo.sv | 89 ++++++++
 rtl/keypad_scan_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
// Shared types and helpers for the 4x4 keypad scan controller:
//   - kp_state_e : debounce FSM states
//   - KEY_W / NUM_COLS / NUM_ROWS : matrix geometry
//   - key_code() : (column, row) -> 4-bit key code
//   - first_set(): lowest pressed key in a full-scan snapshot
// ---------------------------------------------------------------------------
package keypad_pkg;

    localparam int KEY_W    = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;
    localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } kp_state_e;

    // col_idx*4 + row_idx; with four rows this is a plain concatenation
    function automatic logic [KEY_W-1:0] key_code(input logic [1:0] col_idx,
                                                  input logic [1:0] row_idx);
        return {col_idx, row_idx};
    endfunction

    // Returns {found, code} for the lowest set bit of the snapshot.
    // Scanning downward lets the last hit (the lowest index) win.
    function automatic logic [KEY_W:0] first_set(input logic [NUM_KEYS-1:0] snap);
        logic [KEY_W:0] res;
        res = {1'b0, 4'd0};
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (snap[i]) begin
                res = {1'b1, key_code(2'(i / NUM_ROWS), 2'(i % NUM_ROWS))};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// keypad_scan_ctrl_if
// Key-event stream between the keypad controller and its consumer.
//   key_code  : FIFO head code
//   key_valid : FIFO non-empty
//   key_ready : consumer accepts the head when key_valid && key_ready
//   key_held  : a debounced key is currently held down
//   overflow  : one-cycle pulse when a debounced code is dropped
// master = controller side, slave = consumer side.
// ---------------------------------------------------------------------------
interface keypad_scan_ctrl_if;
    import keypad_pkg::*;

    logic [KEY_W-1:0] key_code;
    logic             key_valid;
    logic             key_ready;
    logic             key_held;
    logic             overflow;

    modport master (
        output key_code,
        output key_valid,
        output key_held,
        output overflow,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  key_held,
        input  overflow,
        output key_ready
    );

endinterface

// File: rtl/keypad_scan_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// key_fifo
// Synchronous FIFO for debounced key codes.
//   clk, rst  : clock, synchronous active-high reset (contents discarded)
//   push      : write request; dropped when full unless a pop happens too
//   push_data : code to write
//   pop       : read request; ignored while empty
//   pop_data  : head entry
//   full      : FIFO holds DEPTH entries
//   empty     : FIFO holds no entries
//   overflow  : one-cycle pulse after a push was dropped
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// ---------------------------------------------------------------------------
module key_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             full_r;
    logic             empty_r;
    logic             overflow_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests: no pop from empty; a push into a full FIFO only
    // succeeds when a pop frees a slot in the same cycle.
    always_comb begin
        do_pop_s  = pop && !empty_r;
        do_push_s = push && (!full_r || do_pop_s);
        if (do_push_s && !do_pop_s) begin
            count_next_s = count_r + CNT_W'(1);
        end else if (!do_push_s && do_pop_s) begin
            count_next_s = count_r - CNT_W'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Storage, pointers and registered status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r    <= count_next_s;
            full_r     <= (count_next_s == CNT_W'(DEPTH));
            empty_r    <= (count_next_s == CNT_W'(0));
            overflow_r <= push && !do_push_s;
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign full     = full_r;
    assign empty    = empty_r;
    assign overflow = overflow_r;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// ---------------------------------------------------------------------------
// keypad_scan_ctrl
// 4x4 matrix keypad controller: one-hot column scan, row synchronizer,
// press/release debounce FSM and a key-code FIFO with valid/ready handshake.
//   clk  : system clock (rising edge)
//   rst  : synchronous active-high reset
//   fila : row lines, active-high, asynchronous to clk
//   col  : one-hot column drive
//   kif  : key-event stream (key_code/key_valid/key_ready/key_held/overflow)
// ---------------------------------------------------------------------------
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int CLK_DIV        = 65536,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_ROWS-1:0]    fila,
    output logic [NUM_COLS-1:0]    col,
    keypad_scan_ctrl_if.master     kif
);

    localparam int TIMER_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W   = $clog2(DEBOUNCE_SCANS + 1) + 1;

    logic [NUM_ROWS-1:0] sync1_r;
    logic [NUM_ROWS-1:0] sync2_r;
    logic [TIMER_W-1:0]  timer_r;
    logic [1:0]          col_idx_r;
    logic [NUM_COLS-1:0] col_r;
    logic [NUM_KEYS-1:0] snap_r;
    logic                scan_done_r;
    logic                tc_s;

    kp_state_e           state_r;
    kp_state_e           state_next_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_inc_s;
    logic                deb_reached_s;
    logic [KEY_W-1:0]    stored_r;
    logic                held_r;
    logic                cand_valid_s;
    logic [KEY_W-1:0]    cand_s;
    logic                cand_match_s;
    logic                stored_hit_s;

    logic                push_s;
    logic [KEY_W-1:0]    push_code_s;
    logic                pop_s;
    logic [KEY_W-1:0]    fifo_head_s;
    logic                fifo_empty_s;
    logic                fifo_full_unused_s;
    logic                fifo_ovf_s;

    assign tc_s = (timer_r == TIMER_W'(CLK_DIV - 1));

    // Row synchronizer, slot timer, column sequencer and scan snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r     <= '0;
            sync2_r     <= '0;
            timer_r     <= '0;
            col_idx_r   <= 2'd0;
            col_r       <= 4'b0001;
            snap_r      <= '0;
            scan_done_r <= 1'b0;
        end else begin
            sync1_r <= fila;
            sync2_r <= sync1_r;
            if (tc_s) begin
                timer_r   <= '0;
                // The synchronizer output belongs to the column still driven
                snap_r[{col_idx_r, 2'b00} +: NUM_ROWS] <= sync2_r;
                col_idx_r <= col_idx_r + 2'd1;
                col_r     <= 4'b0001 << (col_idx_r + 2'd1);
            end else begin
                timer_r <= timer_r + TIMER_W'(1);
            end
            // Strobe lands one cycle after the last column is written, so the
            // FSM always sees a complete snapshot
            scan_done_r <= tc_s && (col_idx_r == 2'd3);
        end
    end

    // Candidate key and comparisons against the stored key
    always_comb begin
        {cand_valid_s, cand_s} = first_set(snap_r);
        cand_match_s  = cand_valid_s && (cand_s == stored_r);
        stored_hit_s  = snap_r[stored_r];
        cnt_inc_s     = cnt_r + CNT_W'(1);
        deb_reached_s = (cnt_inc_s >= CNT_W'(DEBOUNCE_SCANS));
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; transitions only on scan boundaries
    always_comb begin
        state_next_s = state_r;
        if (scan_done_r) begin
            case (state_r)
                IDLE: begin
                    if (!cand_valid_s) begin
                        state_next_s = IDLE;
                    end else if (DEBOUNCE_SCANS == 1) begin
                        state_next_s = HELD;
                    end else begin
                        state_next_s = PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (!cand_match_s) begin
                        state_next_s = IDLE;
                    end else if (deb_reached_s) begin
                        state_next_s = HELD;
                    end else begin
                        state_next_s = PRESS_WAIT;
                    end
                end
                HELD: begin
                    if (!stored_hit_s) begin
                        state_next_s = RELEASE_WAIT;
                    end else begin
                        state_next_s = HELD;
                    end
                end
                RELEASE_WAIT: begin
                    if (stored_hit_s) begin
                        state_next_s = HELD;
                    end else if (deb_reached_s) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = RELEASE_WAIT;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // FSM outputs: FIFO push and the code to push
    always_comb begin
        push_s      = 1'b0;
        push_code_s = stored_r;
        if (scan_done_r) begin
            case (state_r)
                IDLE: begin
                    if (cand_valid_s && (DEBOUNCE_SCANS == 1)) begin
                        push_s      = 1'b1;
                        push_code_s = cand_s;
                    end else begin
                        push_s      = 1'b0;
                    end
                end
                PRESS_WAIT: begin
                    if (cand_match_s && deb_reached_s) begin
                        push_s = 1'b1;
                    end else begin
                        push_s = 1'b0;
                    end
                end
                default: begin
                    push_s = 1'b0;
                end
            endcase
        end else begin
            push_s = 1'b0;
        end
    end

    // Debounce counter, stored key and registered key_held
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= '0;
            stored_r <= '0;
            held_r   <= 1'b0;
        end else begin
            held_r <= (state_next_s == HELD) || (state_next_s == RELEASE_WAIT);
            if (scan_done_r) begin
                case (state_r)
                    IDLE: begin
                        if (cand_valid_s) begin
                            stored_r <= cand_s;
                            cnt_r    <= CNT_W'(1);
                        end
                    end
                    PRESS_WAIT: begin
                        if (cand_match_s) begin
                            cnt_r <= cnt_inc_s;
                        end
                    end
                    HELD: begin
                        if (!stored_hit_s) begin
                            cnt_r <= CNT_W'(1);
                        end
                    end
                    RELEASE_WAIT: begin
                        if (!stored_hit_s) begin
                            cnt_r <= cnt_inc_s;
                        end
                    end
                    default: begin
                        cnt_r <= '0;
                    end
                endcase
            end
        end
    end

    assign pop_s = !fifo_empty_s && kif.key_ready;

    key_fifo #(
        .WIDTH (KEY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_code_s),
        .pop       (pop_s),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_unused_s),
        .empty     (fifo_empty_s),
        .overflow  (fifo_ovf_s)
    );

    assign col           = col_r;
    assign kif.key_code  = fifo_head_s;
    assign kif.key_valid = !fifo_empty_s;
    assign kif.key_held  = held_r;
    assign kif.overflow  = fifo_ovf_s;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_keypad_scan_ctrl
// Directed bench for keypad_scan_ctrl with CLK_DIV=4, DEBOUNCE_SCANS=2,
// FIFO_DEPTH=4 (one full scan = 16 cycles). The keypad matrix is modelled
// from keys_down: row r is high when any driven column has key (c,r) down.
// ---------------------------------------------------------------------------
module tb_keypad_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  fila;
    logic [3:0]  col;
    logic [15:0] keys_down;

    int errors = 0;
    int checks = 0;

    logic [3:0] pops[$];
    int         ovf_cnt;
    int         valid_cycles;

    keypad_scan_ctrl_if kif();

    keypad_scan_ctrl #(
        .CLK_DIV        (4),
        .DEBOUNCE_SCANS (2),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .fila (fila),
        .col  (col),
        .kif  (kif)
    );

    always #5 clk = ~clk;

    // Keypad matrix model
    always_comb begin
        fila = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (col[c] && keys_down[c*4 + r]) fila[r] = 1'b1;
            end
        end
    end

    // Record handshakes and overflow pulses as seen by the consumer
    always @(posedge clk) begin
        if (kif.key_valid && kif.key_ready) pops.push_back(kif.key_code);
        if (kif.overflow) ovf_cnt++;
        if (kif.key_valid) valid_cycles++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Return on the first negedge of a new scan (column 0 just driven)
    task automatic align_scan();
        logic [3:0] prev;
        logic       found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            prev = col;
            @(negedge clk);
            if (prev == 4'b1000 && col == 4'b0001) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL align_scan: scan start not seen within 40 cycles, col=%b", col);
        end
    endtask

    task automatic clear_obs();
        pops.delete();
        ovf_cnt      = 0;
        valid_cycles = 0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        rst           = 1'b1;
        keys_down     = 16'h0000;
        kif.key_ready = 1'b0;
        cyc(3);
        checks++;
        if (col !== 4'b0001) begin errors++; $display("FAIL reset_col: got %b want 0001", col); end
        checks++;
        if ({kif.key_valid, kif.key_held, kif.overflow} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got v/h/o=%b want 000",
                               {kif.key_valid, kif.key_held, kif.overflow});
        end
        checks++;
        if (kif.key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", kif.key_code); end
        rst = 1'b0;
        clear_obs();
        for (int k = 0; k < 20; k++) begin
            exp_col = 4'b0001 << ((k / 4) % 4);
            checks++;
            if (col !== exp_col) begin
                errors++; $display("FAIL col_seq[%0d]: got %b want %b", k, col, exp_col);
            end
            cyc(1);
        end
        checks++;
        if (valid_cycles != 0 || ovf_cnt != 0 || kif.key_held !== 1'b0) begin
            errors++; $display("FAIL idle_quiet: valid_cycles=%0d ovf=%0d held=%b want 0/0/0",
                               valid_cycles, ovf_cnt, kif.key_held);
        end
    endtask

    task automatic test_single_key();
        kif.key_ready = 1'b1;
        align_scan();
        clear_obs();
        keys_down[1] = 1'b1;
        cyc(32);
        checks++;
        if (kif.key_valid !== 1'b0 || kif.key_held !== 1'b0) begin
            errors++; $display("FAIL pre_accept: valid=%b held=%b want 0/0", kif.key_valid, kif.key_held);
        end
        cyc(1);
        checks++;
        if (kif.key_valid !== 1'b1 || kif.key_code !== 4'd1 || kif.key_held !== 1'b1) begin
            errors++; $display("FAIL accept: valid=%b code=%0d held=%b want 1/1/1",
                               kif.key_valid, kif.key_code, kif.key_held);
        end
        cyc(1);
        checks++;
        if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL popped: valid=%b want 0", kif.key_valid); end
        cyc(62);
        checks++;
        if (kif.key_held !== 1'b1) begin errors++; $display("FAIL held_6scans: held=%b want 1", kif.key_held); end
        keys_down[1] = 1'b0;
        cyc(32);
        checks++;
        if (kif.key_held !== 1'b1) begin errors++; $display("FAIL release_wait_held: held=%b want 1", kif.key_held); end
        cyc(1);
        checks++;
        if (kif.key_held !== 1'b0) begin errors++; $display("FAIL released: held=%b want 0", kif.key_held); end
        checks++;
        if (pops.size() != 1 || valid_cycles != 1) begin
            errors++; $display("FAIL single_event: pops=%0d valid_cycles=%0d want 1/1", pops.size(), valid_cycles);
        end else if (pops[0] !== 4'd1) begin
            errors++; $display("FAIL single_code: got %0d want 1", pops[0]);
        end
    endtask

    task automatic test_bounce();
        kif.key_ready = 1'b1;
        align_scan();
        clear_obs();
        keys_down[5] = 1'b1;
        cyc(16);
        keys_down[5] = 1'b0;
        cyc(48);
        checks++;
        if (valid_cycles != 0 || pops.size() != 0 || kif.key_held !== 1'b0) begin
            errors++; $display("FAIL bounce: valid_cycles=%0d pops=%0d held=%b want 0/0/0",
                               valid_cycles, pops.size(), kif.key_held);
        end
    endtask

    task automatic test_fifo_overflow();
        logic [3:0] seq [5];
        logic [3:0] exp [4];
        seq = '{4'd2, 4'd7, 4'd11, 4'd14, 4'd3};
        exp = '{4'd2, 4'd7, 4'd11, 4'd14};
        kif.key_ready = 1'b0;
        clear_obs();
        for (int i = 0; i < 5; i++) begin
            align_scan();
            keys_down[seq[i]] = 1'b1;
            cyc(64);
            keys_down = 16'h0000;
            cyc(64);
            if (i == 3) begin
                checks++;
                if (ovf_cnt != 0 || kif.key_valid !== 1'b1 || kif.key_code !== 4'd2) begin
                    errors++; $display("FAIL fifo_fill: ovf=%0d valid=%b code=%0d want 0/1/2",
                                       ovf_cnt, kif.key_valid, kif.key_code);
                end
            end
        end
        checks++;
        if (ovf_cnt != 1) begin errors++; $display("FAIL overflow_pulse: got %0d pulses want 1", ovf_cnt); end
        checks++;
        if (kif.key_code !== 4'd2) begin errors++; $display("FAIL head_stable: got %0d want 2", kif.key_code); end
        kif.key_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (kif.key_valid !== 1'b1 || kif.key_code !== exp[i]) begin
                errors++; $display("FAIL drain[%0d]: valid=%b code=%0d want 1/%0d",
                                   i, kif.key_valid, kif.key_code, exp[i]);
            end
            cyc(1);
        end
        checks++;
        if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL drained: valid=%b want 0", kif.key_valid); end
    endtask

    task automatic test_reset_mid_debounce();
        kif.key_ready = 1'b1;
        align_scan();
        clear_obs();
        keys_down[9] = 1'b1;
        cyc(20);
        rst       = 1'b1;
        keys_down = 16'h0000;
        cyc(1);
        checks++;
        if (col !== 4'b0001 || kif.key_held !== 1'b0 || kif.key_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset: col=%b held=%b valid=%b want 0001/0/0",
                               col, kif.key_held, kif.key_valid);
        end
        cyc(1);
        rst = 1'b0;
        cyc(48);
        checks++;
        if (pops.size() != 0 || valid_cycles != 0) begin
            errors++; $display("FAIL reset_no_code: pops=%0d valid_cycles=%0d want 0/0", pops.size(), valid_cycles);
        end
        align_scan();
        keys_down[9] = 1'b1;
        cyc(64);
        keys_down = 16'h0000;
        cyc(64);
        checks++;
        if (pops.size() != 1) begin
            errors++; $display("FAIL repress_count: pops=%0d want 1", pops.size());
        end else if (pops[0] !== 4'd9) begin
            errors++; $display("FAIL repress_code: got %0d want 9", pops[0]);
        end
    endtask

    task automatic test_multi_key();
        kif.key_ready = 1'b1;
        align_scan();
        clear_obs();
        keys_down[6] = 1'b1;
        keys_down[9] = 1'b1;
        cyc(64);
        checks++;
        if (kif.key_held !== 1'b1 || pops.size() != 1) begin
            errors++; $display("FAIL multi_accept: held=%b pops=%0d want 1/1", kif.key_held, pops.size());
        end else if (pops[0] !== 4'd6) begin
            errors++; $display("FAIL multi_lowest: got %0d want 6", pops[0]);
        end
        keys_down[12] = 1'b1;
        cyc(48);
        checks++;
        if (pops.size() != 1 || kif.key_held !== 1'b1) begin
            errors++; $display("FAIL held_ignores: pops=%0d held=%b want 1/1", pops.size(), kif.key_held);
        end
        keys_down = 16'h0000;
        cyc(64);
        checks++;
        if (kif.key_held !== 1'b0 || pops.size() != 1) begin
            errors++; $display("FAIL multi_release: held=%b pops=%0d want 0/1", kif.key_held, pops.size());
        end
    endtask

    initial begin
        rst           = 1'b1;
        keys_down     = 16'h0000;
        kif.key_ready = 1'b0;
        ovf_cnt       = 0;
        valid_cycles  = 0;
        test_reset();
        test_single_key();
        test_bounce();
        test_fifo_overflow();
        test_reset_mid_debounce();
        test_multi_key();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
